// File: rtl/mcycle_unit.sv
// mcycle_unit: iterative unsigned multiply / divide responder for the
// pipeline's multi-cycle start request. One shared WIDTH-bit hi/lo register
// pair serves as the shift-add accumulator (MUL) or the restoring remainder /
// quotient pair (DIV). One iteration is performed per clock; results are
// written once, at the completion edge.
//
// Ports:
//   CLK       in   1      clock, rising edge
//   RESET     in   1      asynchronous, active-high reset
//   Start     in   1      request, sampled only in IDLE
//   MCycleOp  in   1      0 = unsigned multiply, 1 = unsigned divide
//   Operand1  in   WIDTH  MUL multiplicand / DIV dividend
//   Operand2  in   WIDTH  MUL multiplier   / DIV divisor
//   Result1   out  WIDTH  MUL product low half / DIV quotient (registered)
//   Result2   out  WIDTH  MUL product high half / DIV remainder (registered)
//   Busy      out  1      pipeline stall, combinational from state and Start
module mcycle_unit #(
  parameter int unsigned WIDTH = 32
) (
  input  logic             CLK,
  input  logic             RESET,
  input  logic             Start,
  input  logic             MCycleOp,
  input  logic [WIDTH-1:0] Operand1,
  input  logic [WIDTH-1:0] Operand2,
  output logic [WIDTH-1:0] Result1,
  output logic [WIDTH-1:0] Result2,
  output logic             Busy
);

  localparam int unsigned CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(WIDTH - 1);

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    COMPUTING = 2'd1,
    DONE      = 2'd2
  } state_t;

  state_t           state;
  state_t           state_next;
  logic [CNT_W-1:0] count;
  logic             is_div;
  logic [WIDTH-1:0] opnd;      // MUL: multiplicand, DIV: divisor
  logic [WIDTH-1:0] hi;        // MUL: accumulator high, DIV: remainder
  logic [WIDTH-1:0] lo;        // MUL: multiplier / product low, DIV: quotient
  logic [WIDTH-1:0] hi_next;
  logic [WIDTH-1:0] lo_next;
  logic [WIDTH:0]   mul_sum;
  logic [WIDTH:0]   div_shift;
  logic [WIDTH:0]   div_diff;
  logic             last_iter;
  logic             accept;

  assign last_iter = (count == LAST_CNT);
  assign accept    = (state == IDLE) && Start;

  // State register
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Next state and Busy; Busy is forced low while reset is asserted
  always_comb begin
    state_next = state;
    Busy       = 1'b0;
    unique case (state)
      IDLE: begin
        Busy = Start;
        if (Start) begin
          state_next = COMPUTING;
        end
      end
      COMPUTING: begin
        Busy = 1'b1;
        if (last_iter) begin
          state_next = DONE;
        end
      end
      DONE: begin
        // Start still held here belongs to the finished request
        state_next = IDLE;
      end
      default: begin
        state_next = IDLE;
      end
    endcase
    if (RESET) begin
      Busy = 1'b0;
    end
  end

  // One iteration step for either operation
  always_comb begin
    hi_next   = hi;
    lo_next   = lo;
    // Shift-add: add multiplicand into the high half when the multiplier LSB
    // is set, then shift {carry, hi, lo} right by one.
    mul_sum   = {1'b0, hi} + (lo[0] ? {1'b0, opnd} : {(WIDTH+1){1'b0}});
    // Restoring divide: bring the next dividend bit into the remainder and try
    // a WIDTH+1-bit subtract; a clear sign bit means the divisor fits.
    div_shift = {hi, lo[WIDTH-1]};
    div_diff  = div_shift - {1'b0, opnd};
    if (is_div) begin
      if (!div_diff[WIDTH]) begin
        hi_next = div_diff[WIDTH-1:0];
        lo_next = {lo[WIDTH-2:0], 1'b1};
      end else begin
        hi_next = div_shift[WIDTH-1:0];
        lo_next = {lo[WIDTH-2:0], 1'b0};
      end
    end else begin
      hi_next = mul_sum[WIDTH:1];
      lo_next = {mul_sum[0], lo[WIDTH-1:1]};
    end
  end

  // Operand latch, iteration registers and iteration counter
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      count  <= '0;
      is_div <= 1'b0;
      opnd   <= '0;
      hi     <= '0;
      lo     <= '0;
    end else if (accept) begin
      count  <= '0;
      is_div <= MCycleOp;
      opnd   <= MCycleOp ? Operand2 : Operand1;
      hi     <= '0;
      lo     <= MCycleOp ? Operand1 : Operand2;
    end else if (state == COMPUTING) begin
      count <= count + CNT_W'(1);
      hi    <= hi_next;
      lo    <= lo_next;
    end
  end

  // Result registers: written only at the completion edge
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      Result1 <= '0;
      Result2 <= '0;
    end else if ((state == COMPUTING) && last_iter) begin
      Result1 <= lo_next;
      Result2 <= hi_next;
    end
  end

endmodule
